// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and arbiter types
package riscv_pkg;

   // Opcodes shared with the pipelined core
   localparam logic [6:0]  OP_LW    = 7'b0000011;
   localparam logic [6:0]  OP_SW    = 7'b0100011;
   localparam logic [6:0]  OP_BEQ   = 7'b1100011;
   localparam logic [6:0]  OP_ALU   = 7'b0110011;
   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for one single-port unified memory
module unified_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_t state, state_nx;
   owner_t     owner;
   logic [3:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       grant_if, grant_dm;
   logic       rsp_cycle;
   logic       unused_addr_lsbs;

   // Word access only: the byte-offset bits carry no meaning here
   assign unused_addr_lsbs = ^{if_addr[1:0], dm_addr[1:0]};

   // Last RD_WAIT cycle: memory data is valid and gets captured
   assign rsp_cycle = (state == RD_WAIT) && (lat_cnt == 4'd1);
   assign busy      = (state == RD_WAIT);

   // Arbitration, memory strobes and next state; grants are gated off while in reset
   always_comb begin
      grant_if  = 1'b0;
      grant_dm  = 1'b0;
      state_nx  = state;
      if (rst_n && state == IDLE) begin
         if (if_req && (!dm_req || starve_cnt == 4'(STARVE_MAX)))
            grant_if = 1'b1;
         else if (dm_req)
            grant_dm = 1'b1;
      end
      if_ready  = grant_if;
      dm_ready  = grant_dm;
      mem_en    = grant_if | grant_dm;
      mem_we    = grant_dm & dm_we;
      mem_wdata = (grant_dm & dm_we) ? dm_wdata : '0;
      if (grant_dm)
         mem_addr = dm_addr[ADDR_W-1:2];
      else if (grant_if)
         mem_addr = if_addr[ADDR_W-1:2];
      else
         mem_addr = '0;
      case (state)
         IDLE:    if (grant_if || (grant_dm && !dm_we)) state_nx = RD_WAIT;
         RD_WAIT: if (lat_cnt == 4'd1) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Read tracking: owner, latency countdown, response capture and rvalid pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_IF;
         lat_cnt   <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_rvalid <= rsp_cycle && (owner == OWN_IF);
         dm_rvalid <= rsp_cycle && (owner == OWN_DM);
         if (state == IDLE && state_nx == RD_WAIT) begin
            owner   <= grant_dm ? OWN_DM : OWN_IF;
            lat_cnt <= 4'(MEM_LAT);
         end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
         end
         if (rsp_cycle && owner == OWN_IF) if_rdata <= mem_rdata;
         if (rsp_cycle && owner == OWN_DM) dm_rdata <= mem_rdata;
      end
   end

   // Starvation counter: data grants that bypassed a waiting fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (!if_req || grant_if)
         starve_cnt <= '0;
      else if (grant_dm && starve_cnt != 4'(STARVE_MAX))
         starve_cnt <= starve_cnt + 4'd1;
   end

   // Requesters must hold their command stable until accepted
   a_if_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (if_req && !if_ready) |=> (!if_req || $stable(if_addr)));
   a_dm_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (dm_req && !dm_ready) |=> (!dm_req || $stable({dm_we, dm_addr, dm_wdata})));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   localparam int MEM_LAT    = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic        if_ready, if_rvalid, dm_ready, dm_rvalid;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic        mem_en, mem_we, busy;
   logic [29:0] mem_addr;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [64];
   logic [31:0] rd_pipe [MEM_LAT];

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
      .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // mem_model_lat: single-port memory, read data valid MEM_LAT cycles after mem_en
   assign mem_rdata = rd_pipe[MEM_LAT-1];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[5:0]] : 32'h0;
      for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end

   task automatic cycle_start();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h0;
      @(negedge clk);
      total++;
      if ({if_ready, dm_ready, if_rvalid, dm_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 0000000", {if_ready, dm_ready, if_rvalid, dm_rvalid, mem_en, mem_we, busy});
      end
      total++;
      if ({if_rdata, dm_rdata, mem_wdata} !== 96'h0 || mem_addr !== 30'h0) begin
         bad++; $display("FAIL reset_data: got %h %h %h %h want all 0", if_rdata, dm_rdata, mem_wdata, mem_addr);
      end
      cycle_start();
      if_req = 1'b0; dm_req = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_fetch_only();
      int acc = 0;
      for (int c = 0; c < 10; c++) begin
         cycle_start();
         if_req = (acc < 3); if_addr = 32'(acc * 4);
         @(negedge clk);
         total++;
         if (if_ready !== (c == 0 || c == 3 || c == 6)) begin
            bad++; $display("FAIL fetch_ready c%0d: got %b want %b", c, if_ready, (c == 0 || c == 3 || c == 6));
         end
         total++;
         if (if_rvalid !== (c == 3 || c == 6 || c == 9)) begin
            bad++; $display("FAIL fetch_rvalid c%0d: got %b want %b", c, if_rvalid, (c == 3 || c == 6 || c == 9));
         end
         if (c == 3 || c == 6 || c == 9) begin
            total++;
            if (if_rdata !== 32'h1000_0000 + 32'(c / 3 - 1)) begin
               bad++; $display("FAIL fetch_rdata c%0d: got %h want %h", c, if_rdata, 32'h1000_0000 + 32'(c / 3 - 1));
            end
         end
         if (if_ready) acc++;
      end
      if_req = 1'b0;
   endtask

   task automatic test_collision();
      bit if_done = 0, dm_done = 0;
      for (int c = 0; c < 7; c++) begin
         cycle_start();
         if_req = !if_done; if_addr = 32'h0;
         dm_req = !dm_done; dm_we = 1'b0; dm_addr = 32'h40;
         @(negedge clk);
         total++;
         if ({dm_ready, if_ready} !== {c == 0, c == 3}) begin
            bad++; $display("FAIL coll_ready c%0d: got dm=%b if=%b want dm=%b if=%b", c, dm_ready, if_ready, c == 0, c == 3);
         end
         total++;
         if ({dm_rvalid, if_rvalid, busy} !== {c == 3, c == 6, c == 1 || c == 2 || c == 4 || c == 5}) begin
            bad++; $display("FAIL coll_status c%0d: got %b", c, {dm_rvalid, if_rvalid, busy});
         end
         if (c == 0) begin
            total++;
            if (mem_addr !== 30'h10) begin
               bad++; $display("FAIL coll_addr: got %h want 10", mem_addr);
            end
         end
         if (c == 3) begin
            total++;
            if (dm_rdata !== 32'h1000_0010 || if_rdata !== 32'h1000_0002) begin
               bad++; $display("FAIL coll_rdata: got dm=%h if=%h want dm=10000010 if=10000002", dm_rdata, if_rdata);
            end
         end
         if (c == 6) begin
            total++;
            if (if_rdata !== 32'h1000_0000) begin
               bad++; $display("FAIL coll_fetch_rdata: got %h want 10000000", if_rdata);
            end
         end
         if (dm_ready) dm_done = 1;
         if (if_ready) if_done = 1;
      end
      if_req = 1'b0; dm_req = 1'b0;
   endtask

   task automatic test_store_back_to_back();
      for (int c = 0; c < 5; c++) begin
         cycle_start();
         dm_req = (c < 3); dm_we = 1'b1; dm_addr = 32'h10 + 32'(4 * c); dm_wdata = 32'hDEAD_0000 + 32'(c);
         @(negedge clk);
         total++;
         if ({dm_ready, mem_en, mem_we} !== {3{c < 3}}) begin
            bad++; $display("FAIL store_strobe c%0d: got %b", c, {dm_ready, mem_en, mem_we});
         end
         total++;
         if (dm_rvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL store_norsp c%0d: got rvalid=%b busy=%b want 0 0", c, dm_rvalid, busy);
         end
         if (c < 3) begin
            total++;
            if (mem_addr !== 30'(4 + c) || mem_wdata !== 32'hDEAD_0000 + 32'(c)) begin
               bad++; $display("FAIL store_bus c%0d: got %h/%h want %h/%h", c, mem_addr, mem_wdata, 4 + c, 32'hDEAD_0000 + 32'(c));
            end
         end
      end
      dm_req = 1'b0; dm_we = 1'b0;
      total++;
      if (mem[4] !== 32'hDEAD_0000 || mem[5] !== 32'hDEAD_0001 || mem[6] !== 32'hDEAD_0002) begin
         bad++; $display("FAIL store_mem: got %h %h %h", mem[4], mem[5], mem[6]);
      end
   endtask

   task automatic test_starvation();
      int ifk = 0, dk = 0;
      bit exp_dm, exp_if;
      for (int c = 0; c < 15; c++) begin
         cycle_start();
         if_req = (ifk == 0) || (ifk == 1 && c >= 7);
         if_addr = (ifk == 0) ? 32'h8 : 32'hC;
         dm_req = (c <= 11); dm_we = 1'b1; dm_addr = 32'h20 + 32'(4 * dk); dm_wdata = 32'h5A00_0000 + 32'(dk);
         @(negedge clk);
         exp_dm = (c <= 3) || (c >= 7 && c <= 10);
         exp_if = (c == 4) || (c == 11);
         total++;
         if ({dm_ready, if_ready} !== {exp_dm, exp_if}) begin
            bad++; $display("FAIL starve_grant c%0d: got dm=%b if=%b want dm=%b if=%b", c, dm_ready, if_ready, exp_dm, exp_if);
         end
         total++;
         if (if_rvalid !== (c == 7 || c == 14)) begin
            bad++; $display("FAIL starve_rvalid c%0d: got %b want %b", c, if_rvalid, (c == 7 || c == 14));
         end
         if (c == 7 || c == 14) begin
            total++;
            if (if_rdata !== ((c == 7) ? 32'h1000_0002 : 32'h1000_0003)) begin
               bad++; $display("FAIL starve_rdata c%0d: got %h want %h", c, if_rdata, (c == 7) ? 32'h1000_0002 : 32'h1000_0003);
            end
         end
         if (if_ready) ifk++;
         if (dm_ready) dk++;
      end
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      for (int c = 0; c < 7; c++) begin
         cycle_start();
         rst_n = !(c == 1 || c == 2);
         dm_req = (c == 0); dm_we = 1'b0; dm_addr = 32'h44;
         @(negedge clk);
         if (c == 0) begin
            total++;
            if (dm_ready !== 1'b1) begin
               bad++; $display("FAIL rst_mid_accept: got %b want 1", dm_ready);
            end
         end
         if (c == 1) begin
            total++;
            if ({dm_rvalid, if_rvalid, busy, mem_en} !== 4'b0 || {dm_rdata, if_rdata} !== 64'h0) begin
               bad++; $display("FAIL rst_mid_outputs: got %b %h %h want 0", {dm_rvalid, if_rvalid, busy, mem_en}, dm_rdata, if_rdata);
            end
         end
         if (c >= 3) begin
            total++;
            if (dm_rvalid !== 1'b0 || busy !== 1'b0) begin
               bad++; $display("FAIL rst_mid_norsp c%0d: got rvalid=%b busy=%b want 0 0", c, dm_rvalid, busy);
            end
         end
      end
   endtask

   task automatic test_addr_lsbs();
      for (int c = 0; c < 4; c++) begin
         cycle_start();
         dm_req = (c == 0); dm_we = 1'b0; dm_addr = 32'h43;
         @(negedge clk);
         if (c == 0) begin
            total++;
            if (dm_ready !== 1'b1 || mem_addr !== 30'h10) begin
               bad++; $display("FAIL lsb_accept: got ready=%b addr=%h want 1 10", dm_ready, mem_addr);
            end
         end
         total++;
         if (dm_rvalid !== (c == 3)) begin
            bad++; $display("FAIL lsb_rvalid c%0d: got %b want %b", c, dm_rvalid, c == 3);
         end
         if (c == 3) begin
            total++;
            if (dm_rdata !== 32'h1000_0010) begin
               bad++; $display("FAIL lsb_rdata: got %h want 10000010", dm_rdata);
            end
         end
      end
      dm_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
      for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = 32'h0;
      test_reset();
      test_fetch_only();
      test_collision();
      test_store_back_to_back();
      test_starvation();
      test_reset_mid_read();
      test_addr_lsbs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
